// File: rtl/line_window_reader.sv
// Streams a raster through two cascaded line memories and emits 3-line vertical windows.
// Optional border replication for the first two lines is enabled by defining LINE_WINDOW_BORDER_EN.
module line_window_reader #(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int IMG_WIDTH_LINE = 800,
    parameter int IMG_HEIGHT     = 600
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [IMG_WIDTH_DATA-1:0] din,
    output logic                      out_valid,
    output logic [IMG_WIDTH_DATA-1:0] out_top,
    output logic [IMG_WIDTH_DATA-1:0] out_mid,
    output logic [IMG_WIDTH_DATA-1:0] out_bot,
    output logic [10:0]               out_col,
    output logic [10:0]               out_line,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof
);

    // state  | meaning
    // IDLE   | waiting for in_sof; other pixels are dropped
    // FILL0  | receiving line 0 into L1
    // FILL1  | receiving line 1; line 0 moves to L2
    // STREAM | lines 2..IMG_HEIGHT-1, one window per accepted pixel

`ifdef LINE_WINDOW_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    localparam int          AW             = (IMG_WIDTH_LINE > 1) ? $clog2(IMG_WIDTH_LINE) : 1;
    localparam logic [10:0] COL_LAST       = 11'(IMG_WIDTH_LINE - 1);
    localparam logic [10:0] LINE_LAST      = 11'(IMG_HEIGHT - 1);
    localparam logic [10:0] FIRST_OUT_LINE = BORDER ? 11'd0 : 11'd2;

    typedef enum logic [1:0] {IDLE, FILL0, FILL1, STREAM} state_t;

    state_t state_q, state_d;
    logic [10:0] col_q, col_d, line_q, line_d;
    logic [10:0] pix_col, pix_line;
    logic        accept, produce;
    logic [IMG_WIDTH_DATA-1:0] l1_rd, l2_rd, top_d, mid_d;

    logic [IMG_WIDTH_DATA-1:0] l1_mem [IMG_WIDTH_LINE];
    logic [IMG_WIDTH_DATA-1:0] l2_mem [IMG_WIDTH_LINE];

    // Asynchronous read gives read-before-write at the accepted address.
    assign l1_rd = l1_mem[pix_col[AW-1:0]];
    assign l2_rd = l2_mem[pix_col[AW-1:0]];

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        line_d   = line_q;
        accept   = 1'b0;
        produce  = 1'b0;
        pix_col  = col_q;
        pix_line = line_q;
        if (in_valid) begin
            if (in_sof) begin
                // Frame start; an sof outside IDLE aborts and restarts without output.
                accept   = 1'b1;
                pix_col  = '0;
                pix_line = '0;
                col_d    = 11'd1;
                line_d   = '0;
                state_d  = FILL0;
                produce  = BORDER && (state_q == IDLE);
            end else if (state_q != IDLE) begin
                accept = 1'b1;
                if (col_q == COL_LAST) begin
                    col_d  = '0;
                    line_d = line_q + 11'd1;
                end else begin
                    col_d = col_q + 11'd1;
                end
                case (state_q)
                    FILL0: begin
                        produce = BORDER;
                        if (col_q == COL_LAST) state_d = FILL1;
                    end
                    FILL1: begin
                        produce = BORDER;
                        if (col_q == COL_LAST) state_d = STREAM;
                    end
                    STREAM: begin
                        produce = 1'b1;
                        if (col_q == COL_LAST && line_q == LINE_LAST) begin
                            state_d = IDLE;
                            col_d   = '0;
                            line_d  = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        top_d = l2_rd;
        mid_d = l1_rd;
        if (BORDER) begin
            if (state_q == FILL1) begin
                top_d = l1_rd;
            end else if (state_q != STREAM) begin
                top_d = din;
                mid_d = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            l1_mem[pix_col[AW-1:0]] <= din;
            l2_mem[pix_col[AW-1:0]] <= l1_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            out_top   <= '0;
            out_mid   <= '0;
            out_bot   <= '0;
            out_col   <= '0;
            out_line  <= '0;
        end else begin
            out_valid <= produce;
            out_sof   <= produce && (pix_line == FIRST_OUT_LINE) && (pix_col == '0);
            out_eol   <= produce && (pix_col == COL_LAST);
            out_eof   <= produce && (pix_col == COL_LAST) && (pix_line == LINE_LAST);
            if (produce) begin
                out_top  <= top_d;
                out_mid  <= mid_d;
                out_bot  <= din;
                out_col  <= pix_col;
                out_line <= pix_line;
            end
        end
    end

endmodule

// File: doc/line_window_reader.md
LINE_WINDOW_READER -- requirements
Module: line_window_reader

Interface
REQ-001 SHALL have parameter IMG_WIDTH_DATA, default 24, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH_LINE, default 800, pixels per line (2..2047).
REQ-003 SHALL have parameter IMG_HEIGHT, default 600, lines per frame (3..2047).
REQ-004 SHALL have port clk  input  1  the only clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  din carries a pixel this cycle.
REQ-007 SHALL have port in_sof  input  1  qualified by in_valid; pixel is column 0, line 0 of a frame.
REQ-008 SHALL have port din  input  IMG_WIDTH_DATA  incoming raster pixel.
REQ-009 SHALL have port out_valid  output  1  output column valid this cycle.
REQ-010 SHALL have ports out_top, out_mid, out_bot  output  IMG_WIDTH_DATA each  pixels at the same column from lines n-2, n-1, n.
REQ-011 SHALL have ports out_col, out_line  output  11 each  column and line index n of out_bot.
REQ-012 SHALL have ports out_sof, out_eol, out_eof  output  1 each  first column of window output, last column of line, last column of frame.

Function
REQ-013 SHALL contain two internal line memories of IMG_WIDTH_LINE x IMG_WIDTH_DATA, cascaded: L1 holds line n-1, L2 holds line n-2.
REQ-014 SHALL accept a pixel only when in_valid=1; on accept, write din to L1[col] and old L1[col] to L2[col], read-before-write at the same address.
REQ-015 SHALL keep 11-bit col and line counters; col wraps IMG_WIDTH_LINE-1 -> 0 and increments line on wrap.
REQ-016 SHALL implement states IDLE, FILL0, FILL1, STREAM.
REQ-017 IDLE: ignore in_valid without in_sof; in_valid&in_sof -> accept pixel as col 0 line 0, go FILL0.
REQ-018 FILL0 -> FILL1 on accept of col IMG_WIDTH_LINE-1; FILL1 -> STREAM likewise.
REQ-019 STREAM: every accept produces one output; accept of col IMG_WIDTH_LINE-1, line IMG_HEIGHT-1 -> IDLE.
REQ-020 in_valid&in_sof in any non-IDLE state SHALL abort the frame: counters restart, pixel becomes col 0 line 0, state FILL0; no output for the aborted pixel.
REQ-021 Output latency SHALL be exactly 1 cycle: all out_* registered, out_valid high the cycle after an accepted pixel that produces output, low otherwise.
REQ-022 out_top=old L2[col], out_mid=old L1[col], out_bot=din of the accepted pixel.
REQ-023 out_sof=1 only with first output of a frame; out_eol=1 when out_col=IMG_WIDTH_LINE-1; out_eof=1 when also out_line=IMG_HEIGHT-1.
REQ-024 Gaps (in_valid=0) SHALL stall all counters and memories with no effect on data.
REQ-025 Data/index outputs SHALL hold last value when out_valid=0.

Reset
REQ-026 reset=1 SHALL force state IDLE, col=0, line=0, out_valid=0, out_sof/eol/eof=0, out_top/mid/bot=0, out_col=0, out_line=0 on the next edge.
REQ-027 reset mid-frame SHALL discard the frame; memory contents need not be cleared; reset SHALL take priority over in_valid.

Configuration
REQ-028 Macro LINE_WINDOW_BORDER_EN SHALL, when defined, enable border replication: outputs also produced in FILL0 (top=mid=bot=din) and FILL1 (top=mid=old L1[col], bot=din), out_sof on line 0 col 0.
REQ-029 Without LINE_WINDOW_BORDER_EN, no output in FILL0/FILL1; first output is line 2 col 0.

Verification (IMG_WIDTH_LINE=4, IMG_HEIGHT=4, pixel value = 16*line+col)
REQ-030 Reset then full frame continuous in_valid -> 8 outputs (macro off), first: top=0x00 mid=0x10 bot=0x20 out_sof=1 out_line=2; last out_eof=1 bot=0x33.
REQ-031 Same frame, in_valid toggled every other cycle -> identical output sequence, each 1 cycle after its accept.
REQ-032 in_valid pixels before any in_sof -> out_valid stays 0, state IDLE.
REQ-033 in_sof reasserted at line 2 col 1 -> no further outputs until new frame line 2; new outputs use only new-frame data.
REQ-034 reset asserted during line 3 col 2 -> next cycle out_valid=0, all outputs 0; subsequent frame correct.
REQ-035 Macro on, full frame -> 16 outputs; line 0 col 1: top=mid=bot=0x01; line 1 col 1: top=mid=0x01 bot=0x11.
